// File: rtl/wt_dcache_rd_ctrl_gen.sv
// Read-port controller for the write-through L1 dcache: load acceptance, hit check,
// miss/NC issue with a bounded replay budget and saturating event counters.
module wt_dcache_rd_ctrl_gen #(
    parameter int unsigned RdTxId    = 1,
    parameter int unsigned CacheIdW  = 3,
    parameter int unsigned TagW      = 44,
    parameter int unsigned IdxW      = 8,
    parameter int unsigned OffW      = 4,
    parameter int unsigned Ways      = 4,
    parameter int unsigned DataW     = 64,
    parameter int unsigned SigW      = 14,
    parameter int unsigned MaxReplay = 4,
    parameter int unsigned CntW      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cache_en_i,
    // core load port
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [IdxW+OffW-1:0]     idx_i,
    input  logic [1:0]               size_i,
    input  logic [TagW-1:0]          tag_i,
    input  logic                     tag_valid_i,
    input  logic [SigW-1:0]          sig_i,
    input  logic                     cacheable_i,
    input  logic                     kill_i,
    output logic                     rvalid_o,
    output logic [DataW-1:0]         rdata_o,
    // tag/data memories
    output logic                     rd_req_o,
    input  logic                     rd_ack_i,
    output logic [TagW-1:0]          rd_tag_o,
    output logic [IdxW-1:0]          rd_idx_o,
    output logic [OffW-1:0]          rd_off_o,
    input  logic [DataW-1:0]         rd_data_i,
    input  logic [Ways-1:0]          rd_vld_bits_i,
    input  logic [Ways-1:0]          rd_hit_oh_i,
    input  logic                     wr_cl_vld_i,
    // miss unit
    output logic                     miss_req_o,
    input  logic                     miss_ack_i,
    input  logic                     miss_replay_i,
    input  logic                     miss_rtrn_vld_i,
    output logic [TagW+IdxW+OffW-1:0] miss_paddr_o,
    output logic                     miss_nc_o,
    output logic [2:0]               miss_size_o,
    output logic [Ways-1:0]          miss_vld_bits_o,
    output logic [SigW-1:0]          miss_sig_o,
    output logic [CacheIdW-1:0]      miss_id_o,
    // event counters
    input  logic                     cnt_clr_i,
    output logic [CntW-1:0]          cnt_hit_o,
    output logic [CntW-1:0]          cnt_miss_o,
    output logic [CntW-1:0]          cnt_replay_o,
    output logic [CntW-1:0]          cnt_esc_o
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MISS_REQ,
        MISS_WAIT,
        REPLAY_REQ,
        REPLAY_READ,
        KILL_MISS_ACK,
        KILL_MISS
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxW+OffW-1:0]    idx_q, idx_d, idx_mux;
    logic [1:0]              size_q, size_d;
    logic [TagW-1:0]         tag_q, tag_d;
    logic [SigW-1:0]         sig_q, sig_d;
    logic                    cacheable_q, cacheable_d;
    logic [3:0]              replay_cnt_q, replay_cnt_d;
    logic                    esc_q, esc_d;
    logic                    ack_q;
    logic                    rd_req_q;
    logic [Ways-1:0]         vld_bits_q;
    logic [CntW-1:0]         cnt_hit_q, cnt_miss_q, cnt_replay_q, cnt_esc_q;

    logic new_req;
    logic cap_tag;
    logic collide;
    logic budget_spent;
    logic replay_inc;
    logic esc_set;
    logic hit_evt;
    logic miss_evt;

    assign budget_spent = (replay_cnt_q == 4'(MaxReplay));
    assign replay_inc   = collide & ~budget_spent;
    assign esc_set      = collide & budget_spent;

    always_comb begin
        state_d    = state_q;
        gnt_o      = 1'b0;
        rvalid_o   = 1'b0;
        rd_req_o   = 1'b0;
        miss_req_o = 1'b0;
        new_req    = 1'b0;
        cap_tag    = 1'b0;
        collide    = 1'b0;
        miss_evt   = 1'b0;

        unique case (state_q)
            IDLE: begin
                rd_req_o = req_i;
                new_req  = req_i;
                if (req_i && rd_ack_i) begin
                    gnt_o   = 1'b1;
                    state_d = READ;
                end
            end
            READ, REPLAY_READ: begin
                rd_req_o = 1'b1;
                if (kill_i) begin
                    rvalid_o = 1'b1;
                    state_d  = IDLE;
                end else if (tag_valid_i || state_q == REPLAY_READ) begin
                    cap_tag = (state_q == READ);
                    if (wr_cl_vld_i || !ack_q) begin
                        collide = 1'b1;
                        state_d = budget_spent ? MISS_REQ : REPLAY_REQ;
                    end else if (|rd_hit_oh_i && cache_en_i) begin
                        // a hit frees the port this cycle, so a new load may be granted now
                        rvalid_o = 1'b1;
                        new_req  = req_i;
                        state_d  = IDLE;
                        if (req_i && rd_ack_i) begin
                            gnt_o   = 1'b1;
                            state_d = READ;
                        end
                    end else begin
                        state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                miss_req_o = 1'b1;
                if (kill_i) begin
                    rvalid_o = 1'b1;
                    state_d  = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
                end else if (miss_replay_i) begin
                    collide = 1'b1;
                    state_d = budget_spent ? MISS_REQ : REPLAY_REQ;
                end else if (miss_ack_i) begin
                    miss_evt = 1'b1;
                    state_d  = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (miss_rtrn_vld_i) begin
                    rvalid_o = 1'b1;
                    state_d  = IDLE;
                end else if (kill_i) begin
                    rvalid_o = 1'b1;
                    state_d  = KILL_MISS;
                end
            end
            REPLAY_REQ: begin
                rd_req_o = 1'b1;
                if (kill_i) begin
                    rvalid_o = 1'b1;
                    state_d  = IDLE;
                end else if (rd_ack_i) begin
                    state_d = REPLAY_READ;
                end
            end
            KILL_MISS_ACK: begin
                miss_req_o = 1'b1;
                if (miss_replay_i) begin
                    state_d = IDLE;
                end else if (miss_ack_i) begin
                    state_d = KILL_MISS;
                end
            end
            KILL_MISS: begin
                if (miss_rtrn_vld_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hit_evt = rvalid_o & ((state_q == READ) | (state_q == REPLAY_READ));

    always_comb begin
        idx_d        = gnt_o ? idx_i : idx_q;
        size_d       = gnt_o ? size_i : size_q;
        tag_d        = cap_tag ? tag_i : tag_q;
        sig_d        = cap_tag ? sig_i : sig_q;
        cacheable_d  = cap_tag ? cacheable_i : cacheable_q;
        replay_cnt_d = replay_cnt_q;
        esc_d        = esc_q;
        if (gnt_o) begin
            replay_cnt_d = '0;
            esc_d        = 1'b0;
        end else begin
            if (replay_inc) replay_cnt_d = replay_cnt_q + 4'd1;
            if (esc_set)    esc_d        = 1'b1;
        end
    end

    function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] c,
                                                 input logic inc, input logic clr);
        if (clr) return '0;
        if (inc && c != '1) return c + CntW'(1);
        return c;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            size_q       <= '0;
            tag_q        <= '0;
            sig_q        <= '0;
            cacheable_q  <= 1'b0;
            replay_cnt_q <= '0;
            esc_q        <= 1'b0;
            ack_q        <= 1'b0;
            rd_req_q     <= 1'b0;
            vld_bits_q   <= '0;
            cnt_hit_q    <= '0;
            cnt_miss_q   <= '0;
            cnt_replay_q <= '0;
            cnt_esc_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            size_q       <= size_d;
            tag_q        <= tag_d;
            sig_q        <= sig_d;
            cacheable_q  <= cacheable_d;
            replay_cnt_q <= replay_cnt_d;
            esc_q        <= esc_d;
            ack_q        <= rd_ack_i;
            rd_req_q     <= rd_req_o;
            // memory results arrive one cycle after the request
            if (rd_req_q) vld_bits_q <= rd_vld_bits_i;
            cnt_hit_q    <= cnt_next(cnt_hit_q, hit_evt, cnt_clr_i);
            cnt_miss_q   <= cnt_next(cnt_miss_q, miss_evt, cnt_clr_i);
            cnt_replay_q <= cnt_next(cnt_replay_q, replay_inc, cnt_clr_i);
            cnt_esc_q    <= cnt_next(cnt_esc_q, esc_set, cnt_clr_i);
        end
    end

    assign idx_mux  = new_req ? idx_i : idx_q;
    assign rd_idx_o = idx_mux[IdxW+OffW-1:OffW];
    assign rd_off_o = idx_mux[OffW-1:0];
    assign rd_tag_o = tag_d;
    assign rdata_o  = rd_data_i;

    assign miss_nc_o       = ~cache_en_i | ~cacheable_q | esc_q;
    assign miss_size_o     = miss_nc_o ? {1'b0, size_q} : 3'b111;
    assign miss_paddr_o    = {tag_q, idx_q};
    assign miss_vld_bits_o = vld_bits_q;
    assign miss_sig_o      = sig_q;
    assign miss_id_o       = CacheIdW'(RdTxId);

    assign cnt_hit_o    = cnt_hit_q;
    assign cnt_miss_o   = cnt_miss_q;
    assign cnt_replay_o = cnt_replay_q;
    assign cnt_esc_o    = cnt_esc_q;

endmodule

// File: tb/tb_wt_dcache_rd_ctrl_gen.sv
// Directed bench for wt_dcache_rd_ctrl_gen: per-cycle vector table plus hand sequences
// for escalation, kill, NC, counter clear and mid-transaction reset.
module tb_wt_dcache_rd_ctrl_gen;

    localparam int unsigned TagW  = 12;
    localparam int unsigned IdxW  = 6;
    localparam int unsigned OffW  = 4;
    localparam int unsigned Ways  = 4;
    localparam int unsigned DataW = 32;
    localparam int unsigned SigW  = 8;
    localparam int unsigned CntW  = 2;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic                      cache_en_i, req_i, gnt_o;
    logic [IdxW+OffW-1:0]      idx_i;
    logic [1:0]                size_i;
    logic [TagW-1:0]           tag_i;
    logic                      tag_valid_i;
    logic [SigW-1:0]           sig_i;
    logic                      cacheable_i, kill_i, rvalid_o;
    logic [DataW-1:0]          rdata_o;
    logic                      rd_req_o, rd_ack_i;
    logic [TagW-1:0]           rd_tag_o;
    logic [IdxW-1:0]           rd_idx_o;
    logic [OffW-1:0]           rd_off_o;
    logic [DataW-1:0]          rd_data_i;
    logic [Ways-1:0]           rd_vld_bits_i, rd_hit_oh_i;
    logic                      wr_cl_vld_i;
    logic                      miss_req_o, miss_ack_i, miss_replay_i, miss_rtrn_vld_i;
    logic [TagW+IdxW+OffW-1:0] miss_paddr_o;
    logic                      miss_nc_o;
    logic [2:0]                miss_size_o;
    logic [Ways-1:0]           miss_vld_bits_o;
    logic [SigW-1:0]           miss_sig_o;
    logic [2:0]                miss_id_o;
    logic                      cnt_clr_i;
    logic [CntW-1:0]           cnt_hit_o, cnt_miss_o, cnt_replay_o, cnt_esc_o;

    wt_dcache_rd_ctrl_gen #(
        .RdTxId(5), .CacheIdW(3), .TagW(TagW), .IdxW(IdxW), .OffW(OffW), .Ways(Ways),
        .DataW(DataW), .SigW(SigW), .MaxReplay(2), .CntW(CntW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cache_en_i(cache_en_i),
        .req_i(req_i), .gnt_o(gnt_o), .idx_i(idx_i), .size_i(size_i),
        .tag_i(tag_i), .tag_valid_i(tag_valid_i), .sig_i(sig_i), .cacheable_i(cacheable_i),
        .kill_i(kill_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .rd_req_o(rd_req_o), .rd_ack_i(rd_ack_i), .rd_tag_o(rd_tag_o), .rd_idx_o(rd_idx_o),
        .rd_off_o(rd_off_o), .rd_data_i(rd_data_i), .rd_vld_bits_i(rd_vld_bits_i),
        .rd_hit_oh_i(rd_hit_oh_i), .wr_cl_vld_i(wr_cl_vld_i),
        .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i), .miss_replay_i(miss_replay_i),
        .miss_rtrn_vld_i(miss_rtrn_vld_i), .miss_paddr_o(miss_paddr_o), .miss_nc_o(miss_nc_o),
        .miss_size_o(miss_size_o), .miss_vld_bits_o(miss_vld_bits_o), .miss_sig_o(miss_sig_o),
        .miss_id_o(miss_id_o), .cnt_clr_i(cnt_clr_i),
        .cnt_hit_o(cnt_hit_o), .cnt_miss_o(cnt_miss_o), .cnt_replay_o(cnt_replay_o),
        .cnt_esc_o(cnt_esc_o)
    );

    always #5 clk_i = ~clk_i;

    // ctl = {req, ack, tv, wcl, kill, mack, mrep, mrtrn}; exp = {gnt, rvalid, rd_req, miss_req}
    typedef struct {
        logic       req, ack, tv, wcl, kill, mack, mrep, mrtrn;
        logic [3:0] hit;
        logic       gnt, rv, rdreq, mreq;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    function automatic vec_t mkv(input logic [7:0] ctl, input logic [3:0] hit, input logic [3:0] exp);
        vec_t v;
        {v.req, v.ack, v.tv, v.wcl, v.kill, v.mack, v.mrep, v.mrtrn} = ctl;
        v.hit = hit;
        {v.gnt, v.rv, v.rdreq, v.mreq} = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        req_i = v.req; rd_ack_i = v.ack; tag_valid_i = v.tv; wr_cl_vld_i = v.wcl;
        kill_i = v.kill; miss_ack_i = v.mack; miss_replay_i = v.mrep;
        miss_rtrn_vld_i = v.mrtrn; rd_hit_oh_i = v.hit;
        @(negedge clk_i);
        chk({nm, ".gnt"},    64'(gnt_o),      64'(v.gnt));
        chk({nm, ".rvalid"}, 64'(rvalid_o),   64'(v.rv));
        chk({nm, ".rd_req"}, 64'(rd_req_o),   64'(v.rdreq));
        chk({nm, ".mreq"},   64'(miss_req_o), 64'(v.mreq));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input vec_t v, input string nm);
        apply(v, nm);
        tick();
    endtask

    task automatic chk_cnt(input string nm, input int h, input int m, input int r, input int e);
        chk({nm, ".cnt_hit"},    64'(cnt_hit_o),    64'(h));
        chk({nm, ".cnt_miss"},   64'(cnt_miss_o),   64'(m));
        chk({nm, ".cnt_replay"}, 64'(cnt_replay_o), 64'(r));
        chk({nm, ".cnt_esc"},    64'(cnt_esc_o),    64'(e));
    endtask

    task automatic nc_seq(input string nm, input logic cen, input logic cab,
                          input logic [1:0] sz, input logic [3:0] hit);
        cache_en_i = cen; cacheable_i = cab; size_i = sz;
        step(mkv(8'b1100_0000, 4'b0000, 4'b1010), {nm, ".0"});
        size_i = 2'b00;
        step(mkv(8'b0010_0000, hit,     4'b0010), {nm, ".1"});
        apply(mkv(8'b0000_0000, 4'b0000, 4'b0001), {nm, ".2"});
        chk({nm, ".nc"},   64'(miss_nc_o),   64'd1);
        chk({nm, ".size"}, 64'(miss_size_o), 64'({1'b0, sz}));
        tick();
        step(mkv(8'b0000_0100, 4'b0000, 4'b0001), {nm, ".3"});
        step(mkv(8'b0000_0001, 4'b0000, 4'b0100), {nm, ".4"});
        cache_en_i = 1'b1; cacheable_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; cache_en_i = 1'b1; req_i = 1'b0; idx_i = 10'h135; size_i = 2'b01;
        tag_i = 12'h3C5; tag_valid_i = 1'b0; sig_i = 8'h11; cacheable_i = 1'b1; kill_i = 1'b0;
        rd_ack_i = 1'b0; rd_data_i = 32'hCAFE_0001; rd_vld_bits_i = 4'b1011;
        rd_hit_oh_i = '0; wr_cl_vld_i = 1'b0; miss_ack_i = 1'b0; miss_replay_i = 1'b0;
        miss_rtrn_vld_i = 1'b0; cnt_clr_i = 1'b0;

        // reset state
        #12;
        chk("rst.gnt",    64'(gnt_o),      64'd0);
        chk("rst.rvalid", 64'(rvalid_o),   64'd0);
        chk("rst.rd_req", 64'(rd_req_o),   64'd0);
        chk("rst.mreq",   64'(miss_req_o), 64'd0);
        chk("rst.id",     64'(miss_id_o),  64'd5);
        chk_cnt("rst", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // single hit with address/data pass-through
        apply(mkv(8'b1100_0000, 4'b0000, 4'b1010), "hit.0");
        chk("hit.rd_idx", 64'(rd_idx_o), 64'(6'h13));
        chk("hit.rd_off", 64'(rd_off_o), 64'(4'h5));
        tick();
        apply(mkv(8'b0010_0000, 4'b0010, 4'b0110), "hit.1");
        chk("hit.rdata",  64'(rdata_o),  64'h0000_0000_CAFE_0001);
        chk("hit.rd_tag", 64'(rd_tag_o), 64'(12'h3C5));
        tick();
        chk_cnt("hit", 1, 0, 0, 0);

        // cycle table
        tbl.push_back(mkv(8'b1100_0000, 4'b0000, 4'b1010)); //  0 grant
        tbl.push_back(mkv(8'b0010_0000, 4'b0010, 4'b0110)); //  1 hit
        tbl.push_back(mkv(8'b1100_0000, 4'b0000, 4'b1010)); //  2 grant
        tbl.push_back(mkv(8'b1110_0000, 4'b0100, 4'b1110)); //  3 hit + back-to-back grant
        tbl.push_back(mkv(8'b0010_0000, 4'b0001, 4'b0110)); //  4 hit
        tbl.push_back(mkv(8'b0000_0000, 4'b0000, 4'b0000)); //  5 idle
        tbl.push_back(mkv(8'b1100_0000, 4'b0000, 4'b1010)); //  6 grant
        tbl.push_back(mkv(8'b0010_0000, 4'b0000, 4'b0010)); //  7 miss
        tbl.push_back(mkv(8'b0000_0000, 4'b0000, 4'b0001)); //  8 miss_req wait
        tbl.push_back(mkv(8'b0000_0100, 4'b0000, 4'b0001)); //  9 miss ack
        tbl.push_back(mkv(8'b0000_0000, 4'b0000, 4'b0000)); // 10 waiting
        tbl.push_back(mkv(8'b0000_0001, 4'b0000, 4'b0100)); // 11 return
        tbl.push_back(mkv(8'b1100_0000, 4'b0000, 4'b1010)); // 12 grant
        tbl.push_back(mkv(8'b0100_0000, 4'b0000, 4'b0010)); // 13 tag not valid yet
        tbl.push_back(mkv(8'b0110_0000, 4'b1000, 4'b0110)); // 14 hit
        tbl.push_back(mkv(8'b1000_0000, 4'b0000, 4'b0010)); // 15 req without ack
        tbl.push_back(mkv(8'b1100_0000, 4'b0000, 4'b1010)); // 16 grant
        tbl.push_back(mkv(8'b0010_0000, 4'b0010, 4'b0110)); // 17 hit
        tbl.push_back(mkv(8'b1100_0000, 4'b0000, 4'b1010)); // 18 grant
        tbl.push_back(mkv(8'b0000_1000, 4'b0000, 4'b0110)); // 19 kill in READ
        tbl.push_back(mkv(8'b1100_0000, 4'b0000, 4'b1010)); // 20 grant
        tbl.push_back(mkv(8'b0010_0000, 4'b0000, 4'b0010)); // 21 miss
        tbl.push_back(mkv(8'b0000_0100, 4'b0000, 4'b0001)); // 22 miss ack
        tbl.push_back(mkv(8'b0000_1000, 4'b0000, 4'b0100)); // 23 kill in MISS_WAIT
        tbl.push_back(mkv(8'b0000_1000, 4'b0000, 4'b0000)); // 24 kill in KILL_MISS: silent
        tbl.push_back(mkv(8'b0000_0001, 4'b0000, 4'b0000)); // 25 return drained
        tbl.push_back(mkv(8'b0000_0001, 4'b0000, 4'b0000)); // 26 stray return in IDLE
        tbl.push_back(mkv(8'b1100_0000, 4'b0000, 4'b1010)); // 27 grant
        tbl.push_back(mkv(8'b0010_0000, 4'b0000, 4'b0010)); // 28 miss
        tbl.push_back(mkv(8'b0000_0010, 4'b0000, 4'b0001)); // 29 miss replay
        tbl.push_back(mkv(8'b0000_0000, 4'b0000, 4'b0010)); // 30 replay req no ack
        tbl.push_back(mkv(8'b0100_0000, 4'b0000, 4'b0010)); // 31 replay ack
        tbl.push_back(mkv(8'b0000_0000, 4'b0100, 4'b0110)); // 32 replay read hit, no tag_valid
        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));
        chk_cnt("tbl", 3, 2, 1, 0);

        // counter clear wins over a simultaneous hit
        step(mkv(8'b1100_0000, 4'b0000, 4'b1010), "clr.0");
        cnt_clr_i = 1'b1;
        step(mkv(8'b0010_0000, 4'b0010, 4'b0110), "clr.1");
        cnt_clr_i = 1'b0;
        chk_cnt("clr", 0, 0, 0, 0);

        // escalation after MaxReplay=2 collisions
        idx_i = 10'h2A5; size_i = 2'b10; tag_i = 12'hABC; sig_i = 8'h5A;
        step(mkv(8'b1101_0000, 4'b0000, 4'b1010), "esc.0");
        step(mkv(8'b0111_0000, 4'b0010, 4'b0010), "esc.1");
        idx_i = '0; size_i = 2'b00; tag_i = '0; sig_i = 8'h00;
        step(mkv(8'b0101_0000, 4'b0000, 4'b0010), "esc.2");
        step(mkv(8'b0111_0000, 4'b0010, 4'b0010), "esc.3");
        step(mkv(8'b0101_0000, 4'b0000, 4'b0010), "esc.4");
        step(mkv(8'b0111_0000, 4'b0010, 4'b0010), "esc.5");
        apply(mkv(8'b0100_0000, 4'b0000, 4'b0001), "esc.6");
        chk("esc.nc",    64'(miss_nc_o),       64'd1);
        chk("esc.size",  64'(miss_size_o),     64'd2);
        chk("esc.paddr", 64'(miss_paddr_o),    64'({12'hABC, 10'h2A5}));
        chk("esc.sig",   64'(miss_sig_o),      64'h5A);
        chk("esc.vld",   64'(miss_vld_bits_o), 64'(4'b1011));
        tick();
        step(mkv(8'b0000_0100, 4'b0000, 4'b0001), "esc.7");
        step(mkv(8'b0000_0001, 4'b0000, 4'b0100), "esc.8");
        chk_cnt("esc", 0, 1, 2, 1);

        // kill while the miss is unacknowledged
        size_i = 2'b01;
        step(mkv(8'b1100_0000, 4'b0000, 4'b1010), "kill.0");
        step(mkv(8'b0010_0000, 4'b0000, 4'b0010), "kill.1");
        apply(mkv(8'b0000_1000, 4'b0000, 4'b0101), "kill.2");
        chk("kill.nc",   64'(miss_nc_o),   64'd0);
        chk("kill.size", 64'(miss_size_o), 64'(3'b111));
        tick();
        step(mkv(8'b0000_1000, 4'b0000, 4'b0001), "kill.3");
        step(mkv(8'b0000_0010, 4'b0000, 4'b0001), "kill.4");
        step(mkv(8'b0000_0001, 4'b0000, 4'b0000), "kill.5");

        // NC: cache disabled overrides a hit; cacheable_i low on a cached miss
        nc_seq("nc_dis", 1'b0, 1'b1, 2'b11, 4'b0010);
        nc_seq("nc_pma", 1'b1, 1'b0, 2'b01, 4'b0000);

        // reset mid-transaction
        step(mkv(8'b1100_0000, 4'b0000, 4'b1010), "mrst.0");
        step(mkv(8'b0010_0000, 4'b0000, 4'b0010), "mrst.1");
        rst_ni = 1'b0;
        #2;
        chk("mrst.mreq",   64'(miss_req_o), 64'd0);
        chk("mrst.rvalid", 64'(rvalid_o),   64'd0);
        tick();
        rst_ni = 1'b1;
        step(mkv(8'b0000_0101, 4'b0000, 4'b0000), "mrst.2");
        chk_cnt("mrst", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
